// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcodes, FSM state type, default widths.
package alu_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int CMD_W_DEF  = 3;
  localparam int RES_W_DEF  = 2 * DATA_W_DEF;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_AND  = 3'd2;
  localparam logic [2:0] OP_OR   = 3'd3;
  localparam logic [2:0] OP_NOT  = 3'd4;
  localparam logic [2:0] OP_LAST = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/alu_cmd_issuer.sv
// Issues operand/command requests to a sibling combinational ALU and returns the registered result.
// Optional ALU_ISSUER_FLAGS_EN adds registered res_zero/res_neg flag outputs.
module alu_cmd_issuer
  import alu_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int CMD_W  = CMD_W_DEF,
  parameter int RES_W  = 2 * DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [DATA_W-1:0] req_a,
  input  logic [DATA_W-1:0] req_b,
  input  logic [CMD_W-1:0]  req_cmd,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [CMD_W-1:0]  alu_cmd,
  output logic              alu_en,
  input  logic [RES_W-1:0]  alu_d,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [RES_W-1:0]  res_data,
`ifdef ALU_ISSUER_FLAGS_EN
  output logic              res_zero,
  output logic              res_neg,
`endif
  output logic              res_err
);

  state_t           state;
  logic             accept;
  logic             illegal_p0;
  logic [RES_W-1:0] result_p0;

  // In RESP a new request may only enter in the same cycle the held result retires.
  assign req_ready = (state == IDLE) | ((state == RESP) & res_ready);
  assign accept    = req_valid & req_ready;

  // Stage p0: ALU output as seen during EXEC; illegal commands are forced to a zero result.
  assign illegal_p0 = (alu_cmd > CMD_W'(OP_LAST));
  assign result_p0  = illegal_p0 ? '0 : alu_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      alu_a     <= '0;
      alu_b     <= '0;
      alu_cmd   <= '0;
      alu_en    <= 1'b0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_err   <= 1'b0;
`ifdef ALU_ISSUER_FLAGS_EN
      res_zero  <= 1'b0;
      res_neg   <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            alu_a   <= req_a;
            alu_b   <= req_b;
            alu_cmd <= req_cmd;
            alu_en  <= 1'b1;
            state   <= EXEC;
          end
        end
        EXEC: begin
          res_data  <= result_p0;
          res_err   <= illegal_p0;
`ifdef ALU_ISSUER_FLAGS_EN
          res_zero  <= (result_p0 == '0);
          res_neg   <= result_p0[RES_W-1];
`endif
          res_valid <= 1'b1;
          alu_en    <= 1'b0;
          state     <= RESP;
        end
        RESP: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (req_valid) begin
              alu_a   <= req_a;
              alu_b   <= req_b;
              alu_cmd <= req_cmd;
              alu_en  <= 1'b1;
              state   <= EXEC;
            end else begin
              state   <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
